// File: rtl/cdc_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdc_bus_arbiter
// Description : Source-domain controller sharing one multi-bit CDC channel
//               between two requesters. Round-robin arbitration picks a
//               winner, its word is captured onto unsync_bus and held, then a
//               4-phase bus_enable/ack handshake with the destination-side
//               bus synchronizer moves exactly one word per handshake.
//               unsync_bus never changes while bus_enable is high.
//
// Ports       :
//   CLK                    source-domain clock
//   RST                    synchronous active-low reset
//   src0_valid/data/ready  requester 0 (ready = accepted this cycle)
//   src1_valid/data/ready  requester 1
//   ack_async              acknowledge from destination (asynchronous)
//   unsync_bus             held word toward the destination synchronizer
//   bus_enable             level request toward the destination
//   busy                   state is not IDLE
//   last_grant             index of the most recently accepted requester
//   timeout_err            one-cycle pulse when a WAIT_ACK timeout aborts
//
// Build option: define CDC_ARB_TIMEOUT_EN to add a WAIT_ACK watchdog of
//               TIMEOUT_CYCLES cycles; without it timeout_err is tied low and
//               WAIT_ACK waits indefinitely.
//
// Revision    : 1.0  initial release
// ============================================================================
module cdc_bus_arbiter #(
  parameter int BUS_WIDTH      = 8,
  parameter int NUM_STAGES     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 src0_valid,
  input  logic [BUS_WIDTH-1:0] src0_data,
  output logic                 src0_ready,
  input  logic                 src1_valid,
  input  logic [BUS_WIDTH-1:0] src1_data,
  output logic                 src1_ready,
  input  logic                 ack_async,
  output logic [BUS_WIDTH-1:0] unsync_bus,
  output logic                 bus_enable,
  output logic                 busy,
  output logic                 last_grant,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    WAIT_ACK = 2'd2,
    WAIT_CLR = 2'd3
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [NUM_STAGES-1:0] ack_sync;
  logic                  ack_s;
  logic                  grant_idx;
  logic                  accept;
  logic                  to_hit;
  logic                  wd_hit;

  // Parameter sanity hook: a synchronizer shorter than two flops or a
  // zero-length watchdog is not a meaningful configuration.
  if (NUM_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_guard
  end

  // --------------------------------------------------------------------------
  // Ack synchronizer
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[NUM_STAGES-2:0], ack_async};
    end
  end

  assign ack_s = ack_sync[NUM_STAGES-1];

  // --------------------------------------------------------------------------
  // Arbitration: a lone valid wins; on a tie the requester that did not win
  // last time is chosen. Grants are blocked during reset and by a stale ack.
  // --------------------------------------------------------------------------
  assign grant_idx  = src1_valid & (~src0_valid | ~last_grant);
  assign accept     = RST & (state_q == IDLE) & ~ack_s & (src0_valid | src1_valid);
  assign src0_ready = accept & ~grant_idx;
  assign src1_ready = accept &  grant_idx;
  assign busy       = (state_q != IDLE);

  // --------------------------------------------------------------------------
  // Optional WAIT_ACK watchdog
  // --------------------------------------------------------------------------
`ifdef CDC_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_err_q;

  // The hit fires in the TIMEOUT_CYCLES-th WAIT_ACK cycle so bus_enable is
  // high for exactly TIMEOUT_CYCLES cycles before the abort edge.
  assign wd_hit = (state_q == WAIT_ACK) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wd_cnt        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= to_hit;
      if (state_q == WAIT_ACK && state_d == WAIT_ACK) begin
        wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign wd_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    to_hit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_s) begin
          state_d = WAIT_CLR;
        end else if (wd_hit) begin
          state_d = WAIT_CLR;
          to_hit  = 1'b1;
        end
      end
      WAIT_CLR: begin
        if (!ack_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // bus_enable is high exactly while the machine sits in WAIT_ACK, so it is
  // registered from the next state: set on the SETUP exit edge, cleared on
  // the ack (or timeout) edge and on reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      bus_enable <= 1'b0;
      unsync_bus <= '0;
      last_grant <= 1'b1;
    end else begin
      state_q    <= state_d;
      bus_enable <= (state_d == WAIT_ACK);
      if (accept) begin
        unsync_bus <= grant_idx ? src1_data : src0_data;
        last_grant <= grant_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/cdc_bus_arbiter.md
# cdc_bus_arbiter

Source-domain controller that shares one multi-bit clock-domain-crossing channel between two requesters. It round-robin arbitrates, captures the winner's word, and holds it stable on `unsync_bus`. It then runs a 4-phase `bus_enable`/ack handshake with the destination-side bus synchronizer, so exactly one word crosses per handshake and the data never changes while `bus_enable` is high.

## Interface
Parameters:
- `BUS_WIDTH`, 8: width of the data words and of `unsync_bus`.
- `NUM_STAGES`, 2: flop depth of the internal ack synchronizer; must be at least 2.
- `TIMEOUT_CYCLES`, 255: watchdog limit for the WAIT_ACK state; only used when the timeout feature is compiled in.

Ports:
- `CLK`  in  1: the single clock (source domain).
- `RST`  in  1: synchronous, active-low reset.
- `src0_valid`  in  1: requester 0 has a word.
- `src0_data`  in  BUS_WIDTH: requester 0 word.
- `src0_ready`  out  1: requester 0 word is accepted this cycle.
- `src1_valid`, `src1_data`, `src1_ready`: the same three signals for requester 1.
- `ack_async`  in  1: acknowledge from the destination domain; asynchronous to `CLK`.
- `unsync_bus`  out  BUS_WIDTH: held word going to the destination synchronizer.
- `bus_enable`  out  1: level request to the destination.
- `busy`  out  1: high whenever the state is not IDLE.
- `last_grant`  out  1: index of the requester most recently accepted.
- `timeout_err`  out  1: one-cycle pulse when a WAIT_ACK timeout aborts a transfer.

## Operation
Ack synchronizer:
- `ack_async` passes through `NUM_STAGES` flops.
- `ack_s` is the last stage.
- All stages reset to 0.

State machine (registered): IDLE, SETUP, WAIT_ACK, WAIT_CLR.
- **IDLE**, when `ack_s`=0 and any `srcN_valid`=1:
  - Grant a requester: the single valid one, or if both are valid, the one not equal to `last_grant`.
  - `srcN_ready` = (state==IDLE) & `ack_s`=0 & grantN, decoded combinationally. At most one ready is high per cycle.
  - On the accept edge, `unsync_bus` loads the granted data, `last_grant` takes the granted index, and the state goes to SETUP.
- **SETUP**: one cycle. On exit, `bus_enable` is set to 1 and the state goes to WAIT_ACK.
- **WAIT_ACK**: hold. When `ack_s`=1, clear `bus_enable` and go to WAIT_CLR.
- **WAIT_CLR**: hold. When `ack_s`=0, go to IDLE.
- `unsync_bus` changes only on an accept edge, so it is stable from SETUP until the next accept.
- IDLE with `ack_s`=1 (a stale ack) blocks grants; no ready is asserted.
- Neither requester is accepted while `busy`=1.

Reset values:
- `bus_enable`=0, `unsync_bus`=0, `last_grant`=1 (so src0 wins the first tie).
- `busy`=0, `timeout_err`=0, both `srcN_ready`=0, state IDLE, watchdog counter 0.
- Reset mid-transfer drops `bus_enable` on the reset edge and abandons the word. The destination sees a falling enable with no new rising edge, so no spurious transfer occurs.

## Timing
- An accept in cycle N gives `unsync_bus` valid from N+1 and `bus_enable`=1 from N+2. Data has one full cycle of setup before enable.
- `bus_enable` falls on the edge after `ack_s` is first seen high. It does not fall before the ack has propagated through all `NUM_STAGES` flops.
- Minimum spacing between two accepts: 4 + 2×`NUM_STAGES` + (destination response) cycles.
- `srcN_valid` may stay high across transfers. A requester holding valid while losing arbitration is served next under round-robin, so there is no starvation.

## Configuration
Macro `CDC_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter of width clog2(`TIMEOUT_CYCLES`+1) counts cycles spent in WAIT_ACK and clears on any other state.
  - When it reaches `TIMEOUT_CYCLES` with `ack_s` still 0: `bus_enable` clears, `timeout_err` pulses for 1 cycle, and the state goes to WAIT_CLR.
  - WAIT_CLR has no timeout.
- **Not defined:**
  - No counter is built and `timeout_err` is tied to 0.
  - WAIT_ACK waits indefinitely.

## Test plan
- **Reset:** hold `RST`=0 for 3 cycles with both valids high, then release. All outputs read 0 except `last_grant`=1, and no ready is asserted during reset.
- **Single transfer:** `src0_valid`=1, `src0_data`=0xA5. `src0_ready` pulses in cycle N, `unsync_bus`=0xA5 at N+1, `bus_enable`=1 at N+2. Raise `ack_async`; `bus_enable` falls `NUM_STAGES`+1 edges later. Drop ack; `busy` clears.
- **Round-robin:** both valid continuously, src0=0x11, src1=0x22, 4 handshakes. Accept order is 0,1,0,1 and `unsync_bus` reads 0x11, 0x22, 0x11, 0x22.
- **Stale ack:** `ack_async`=1 in IDLE with `src1_valid`=1. No ready while ack is high; the accept occurs 1 cycle after `ack_s` returns to 0.
- **Reset mid-handshake:** assert `RST` in WAIT_ACK. `bus_enable` is 0 on the next edge; after release, a new `src0` word transfers normally.
- **Timeout (with `CDC_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=10):** never ack. `bus_enable` is high for exactly 10 cycles, `timeout_err` pulses once, and the block returns to IDLE once `ack_s` is 0.
